psum_accum_writer: RTL and testbench

- Downstream consumer of the psum index generator in the CNN accelerator datapath.
- Each accepted beat carries a (psum, channel, row, col) index tuple and a signed partial sum from the PE array.
- Performs read-modify-write accumulation into the psum SRAM and forwards over in-flight writes to avoid RAW hazards.
- Drives `await` back to the generator as backpressure.

---
 rtl/psum_pkg.sv | 27 ++
 rtl/psum_sat_adder.sv | 29 ++
 rtl/psum_accum_writer.sv | 178 +++++++++++++++++
 tb/tb_psum_accum_writer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared widths, FSM state type and SRAM address packing for the psum accumulation writer.
package psum_pkg;

    localparam int PSUM_N_IDX_W  = 3;
    localparam int PSUM_CH_IDX_W = 8;
    localparam int PSUM_ROW_W    = 6;
    localparam int PSUM_COL_W    = 6;
    localparam int PSUM_DATA_W   = 16;
    localparam int PSUM_ADDR_W   = PSUM_N_IDX_W + PSUM_CH_IDX_W + PSUM_ROW_W + PSUM_COL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } psum_state_e;

    function automatic logic [PSUM_ADDR_W-1:0] psum_pack_addr(
        input logic [PSUM_N_IDX_W-1:0]  n_idx,
        input logic [PSUM_CH_IDX_W-1:0] ch_idx,
        input logic [PSUM_ROW_W-1:0]    row_idx,
        input logic [PSUM_COL_W-1:0]    col_idx
    );
        return {n_idx, ch_idx, row_idx, col_idx};
    endfunction

endpackage

// File: rtl/psum_sat_adder.sv
// Combinational signed adder for psum accumulation; wraps by default, clamps when
// PSUM_SATURATE_EN is defined. ovf_o flags signed overflow of the raw sum either way.
module psum_sat_adder
    import psum_pkg::*;
#(
    parameter int DATA_W = PSUM_DATA_W
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] sum_o,
    output logic                     ovf_o
);

    logic signed [DATA_W-1:0] raw_sum;

    assign raw_sum = a_i + b_i;
    // Overflow only when both operands share a sign that the result does not.
    assign ovf_o   = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (raw_sum[DATA_W-1] != a_i[DATA_W-1]);

`ifdef PSUM_SATURATE_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    assign sum_o = ovf_o ? (a_i[DATA_W-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
    assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/psum_accum_writer.sv
// Read-modify-write psum accumulator with C/D write forwarding and generator backpressure.
// Optional PSUM_SATURATE_EN: saturating add plus a per-job sticky sat_flag output.
//
// state | meaning
// IDLE  | waiting for start; first_pass sampled on start
// RUN   | accepting beats while mem_grant is high
// DRAIN | generator finished; letting stages B and C empty
// DONE  | single-cycle done pulse
module psum_accum_writer
    import psum_pkg::*;
#(
    parameter int N_IDX_W  = PSUM_N_IDX_W,
    parameter int CH_IDX_W = PSUM_CH_IDX_W,
    parameter int ROW_W    = PSUM_ROW_W,
    parameter int COL_W    = PSUM_COL_W,
    parameter int DATA_W   = PSUM_DATA_W
) (
`ifdef PSUM_SATURATE_EN
    output logic                                        sat_flag,
`endif
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        first_pass,
    input  logic                                        gen_done,
    input  logic                                        in_valid,
    input  logic [N_IDX_W-1:0]                          psum_index,
    input  logic [CH_IDX_W-1:0]                         channel_index,
    input  logic [ROW_W-1:0]                            row_index,
    input  logic [COL_W-1:0]                            col_index,
    input  logic signed [DATA_W-1:0]                    psum_in,
    input  logic                                        mem_grant,
    output logic                                        await,
    output logic                                        rd_en,
    output logic [N_IDX_W+CH_IDX_W+ROW_W+COL_W-1:0]     rd_addr,
    input  logic signed [DATA_W-1:0]                    rd_data,
    output logic                                        wr_en,
    output logic [N_IDX_W+CH_IDX_W+ROW_W+COL_W-1:0]     wr_addr,
    output logic signed [DATA_W-1:0]                    wr_data,
    output logic                                        busy,
    output logic                                        done
);

    localparam int ADDR_W = N_IDX_W + CH_IDX_W + ROW_W + COL_W;

    psum_state_e              state_q, state_d;
    logic                     first_pass_q;
    logic                     accept;
    logic [ADDR_W-1:0]        addr_a;

    logic                     valid_b_q, valid_c_q, valid_d_q;
    logic [ADDR_W-1:0]        addr_b_q, addr_c_q, addr_d_q;
    logic signed [DATA_W-1:0] data_b_q, sum_c_q, sum_d_q;
    logic signed [DATA_W-1:0] old_b, sum_b;
    logic                     add_ovf;

    assign addr_a  = {psum_index, channel_index, row_index, col_index};
    assign accept  = in_valid & ~await;
    assign rd_en   = accept & ~first_pass_q;
    assign rd_addr = rd_en ? addr_a : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (gen_done) state_d = DRAIN;
            DRAIN:   if (!valid_b_q && !valid_c_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        await = 1'b1;
        case (state_q)
            RUN: begin
                busy  = 1'b1;
                await = ~mem_grant;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_pass_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            first_pass_q <= first_pass;
        end
    end

    // Youngest in-flight write wins: C is newer than the D shadow.
    always_comb begin
        old_b = rd_data;
        if (first_pass_q) begin
            old_b = '0;
        end else if (valid_c_q && (addr_c_q == addr_b_q)) begin
            old_b = sum_c_q;
        end else if (valid_d_q && (addr_d_q == addr_b_q)) begin
            old_b = sum_d_q;
        end
    end

    psum_sat_adder #(
        .DATA_W (DATA_W)
    ) u_sat_adder (
        .a_i   (old_b),
        .b_i   (data_b_q),
        .sum_o (sum_b),
        .ovf_o (add_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_b_q <= 1'b0;
            valid_c_q <= 1'b0;
            valid_d_q <= 1'b0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
            addr_d_q  <= '0;
            data_b_q  <= '0;
            sum_c_q   <= '0;
            sum_d_q   <= '0;
        end else begin
            valid_b_q <= accept;
            valid_c_q <= valid_b_q;
            valid_d_q <= valid_c_q;
            if (accept) begin
                addr_b_q <= addr_a;
                data_b_q <= psum_in;
            end
            if (valid_b_q) begin
                addr_c_q <= addr_b_q;
                sum_c_q  <= sum_b;
            end
            if (valid_c_q) begin
                addr_d_q <= addr_c_q;
                sum_d_q  <= sum_c_q;
            end
        end
    end

    assign wr_en   = valid_c_q;
    assign wr_addr = addr_c_q;
    assign wr_data = sum_c_q;

`ifdef PSUM_SATURATE_EN
    logic sat_flag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            sat_flag_q <= 1'b0;
        end else if (valid_b_q && add_ovf) begin
            sat_flag_q <= 1'b1;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    logic unused_add_ovf;
    assign unused_add_ovf = add_ovf;
`endif

endmodule

// File: tb/tb_psum_accum_writer.sv
// Self-checking bench for psum_accum_writer: single-beat vector table plus directed
// multi-cycle sequences (forwarding, grant stalls, reset mid-job, gen_done in IDLE).
module tb_psum_accum_writer;
    import psum_pkg::*;

    localparam int AW = 23;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start, first_pass, gen_done, in_valid, mem_grant;
    logic [2:0]           psum_index;
    logic [7:0]           channel_index;
    logic [5:0]           row_index, col_index;
    logic signed [DW-1:0] psum_in;
    logic                 await, rd_en, wr_en, busy, done;
    logic [AW-1:0]        rd_addr, wr_addr;
    logic signed [DW-1:0] rd_data, wr_data;
`ifdef PSUM_SATURATE_EN
    logic                 sat_flag;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    psum_accum_writer dut (
`ifdef PSUM_SATURATE_EN
        .sat_flag      (sat_flag),
`endif
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .first_pass    (first_pass),
        .gen_done      (gen_done),
        .in_valid      (in_valid),
        .psum_index    (psum_index),
        .channel_index (channel_index),
        .row_index     (row_index),
        .col_index     (col_index),
        .psum_in       (psum_in),
        .mem_grant     (mem_grant),
        .await         (await),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done)
    );

    // SRAM model: synchronous read, read-before-write on the same edge.
    logic signed [DW-1:0] sram [int];
    logic signed [DW-1:0] exp_mem [int];

    function automatic logic signed [DW-1:0] sram_rd(input logic [AW-1:0] a);
        if (sram.exists(int'(a))) return sram[int'(a)];
        return '0;
    endfunction

    function automatic logic signed [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= sram_rd(rd_addr);
        if (wr_en) sram[int'(wr_addr)] = wr_data;
    end

    typedef struct {
        int                   wcyc;
        logic [AW-1:0]        addr;
        logic signed [DW-1:0] data;
    } wr_rec_t;

    wr_rec_t wr_log[$];
    wr_rec_t exp_q[$];

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back('{cyc, wr_addr, wr_data});
    end

    typedef struct {
        logic [2:0]           n;
        logic [7:0]           ch;
        logic [5:0]           row;
        logic [5:0]           col;
        logic signed [DW-1:0] psum;
    } beat_t;

    beat_t beats[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic signed [DW-1:0] v);
        sram[int'(a)]    = v;
        exp_mem[int'(a)] = v;
    endtask

    function automatic logic signed [DW-1:0] model_add(input logic signed [DW-1:0] a,
                                                       input logic signed [DW-1:0] b);
        int s;
        logic [31:0] sv;
        s = int'(a) + int'(b);
`ifdef PSUM_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        sv = s;
        return sv[DW-1:0];
    endfunction

    // Runs one job over the beats queue; mem_grant is low for steps [gate_lo, gate_lo+gate_len).
    task automatic run_stream(input bit fp, input int gate_lo, input int gate_len);
        int                   idx, step, last_acc, done_cyc;
        bit                   got_done;
        logic [AW-1:0]        a;
        logic signed [DW-1:0] nw;
        wr_log.delete();
        exp_q.delete();
        start = 1'b1; first_pass = fp;
        tick();
        start = 1'b0; first_pass = ~fp;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        idx = 0; step = 0; last_acc = 0;
        while (idx < beats.size() && step < 200) begin
            mem_grant     = !(step >= gate_lo && step < gate_lo + gate_len);
            in_valid      = 1'b1;
            psum_index    = beats[idx].n;
            channel_index = beats[idx].ch;
            row_index     = beats[idx].row;
            col_index     = beats[idx].col;
            psum_in       = beats[idx].psum;
            gen_done      = (idx == beats.size() - 1) && mem_grant;
            #2;
            a = {beats[idx].n, beats[idx].ch, beats[idx].row, beats[idx].col};
            if (!mem_grant) begin
                check("await_stalled", {31'b0, await}, 32'd1);
                check("rd_en_stalled", {31'b0, rd_en}, 32'd0);
            end else begin
                check("await_run", {31'b0, await}, 32'd0);
                check("rd_en_accept", {31'b0, rd_en}, {31'b0, !fp});
                if (!fp) check("rd_addr", rd_addr, a);
                nw = fp ? beats[idx].psum : model_add(exp_rd(a), beats[idx].psum);
                exp_mem[int'(a)] = nw;
                exp_q.push_back('{cyc + 2, a, nw});
                last_acc = cyc;
                idx++;
            end
            tick();
            step++;
        end
        in_valid = 1'b0; gen_done = 1'b0; mem_grant = 1'b1;
        check("all_beats_accepted", idx, beats.size());
        got_done = 1'b0; done_cyc = 0;
        for (int w = 0; w < 20 && !got_done; w++) begin
            #2;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end else begin
                tick();
            end
        end
        check("done_seen", {31'b0, got_done}, 32'd1);
        check("done_cycle", done_cyc, last_acc + 4);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        tick();
        #2;
        check("done_one_cycle", {31'b0, done}, 32'd0);
        tick();
        check("wr_count", wr_log.size(), exp_q.size());
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            check("wr_cycle", wr_log[i].wcyc, exp_q[i].wcyc);
            check("wr_addr", wr_log[i].addr, exp_q[i].addr);
            check("wr_data", wr_log[i].data, exp_q[i].data);
        end
        beats.delete();
    endtask

    typedef struct {
        bit                   fp;
        logic [2:0]           n;
        logic [7:0]           ch;
        logic [5:0]           row;
        logic [5:0]           col;
        logic signed [DW-1:0] psum;
        logic signed [DW-1:0] mem;
        logic [AW-1:0]        exp_addr;
        logic signed [DW-1:0] exp_data;
        bit                   exp_sat;
    } tv_t;

    tv_t tbl[6];

`ifdef PSUM_SATURATE_EN
    localparam logic signed [DW-1:0] POS_OVF = 16'sd32767;
    localparam logic signed [DW-1:0] NEG_OVF = -16'sd32768;
`else
    localparam logic signed [DW-1:0] POS_OVF = -16'sd32676;
    localparam logic signed [DW-1:0] NEG_OVF = 16'sd32767;
`endif

    initial begin
        logic [AW-1:0] ax, ay;
        tbl[0] = '{1'b1, 3'd0, 8'h00, 6'd0,  6'd0,  16'sd5,      16'sd99,     23'h000000, 16'sd5,      1'b0};
        tbl[1] = '{1'b0, 3'd0, 8'h00, 6'd1,  6'd1,  -16'sd3,     16'sd10,     23'h000041, 16'sd7,      1'b0};
        tbl[2] = '{1'b0, 3'd7, 8'hFF, 6'd63, 6'd63, -16'sd1,     -16'sd1,     23'h7FFFFF, -16'sd2,     1'b0};
        tbl[3] = '{1'b0, 3'd2, 8'h12, 6'd0,  6'd5,  16'sd100,    16'sd32760,  23'h212005, POS_OVF,     1'b1};
        tbl[4] = '{1'b0, 3'd1, 8'h01, 6'd2,  6'd3,  -16'sd1,     -16'sd32768, 23'h101083, NEG_OVF,     1'b1};
        tbl[5] = '{1'b1, 3'd0, 8'h00, 6'd0,  6'd9,  -16'sd32768, 16'sd5,      23'h000009, -16'sd32768, 1'b0};

        reset = 1'b1;
        start = 1'b0; first_pass = 1'b0; gen_done = 1'b0; in_valid = 1'b0; mem_grant = 1'b1;
        psum_index = '0; channel_index = '0; row_index = '0; col_index = '0; psum_in = '0;
        rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_await", {31'b0, await}, 32'd1);
        check("rst_rd_en", {31'b0, rd_en}, 32'd0);
        check("rst_rd_addr", rd_addr, 32'd0);
        check("rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            preload({tbl[i].n, tbl[i].ch, tbl[i].row, tbl[i].col}, tbl[i].mem);
            beats.push_back('{tbl[i].n, tbl[i].ch, tbl[i].row, tbl[i].col, tbl[i].psum});
            run_stream(tbl[i].fp, 1000, 0);
            if (wr_log.size() > 0) begin
                check($sformatf("tbl%0d_addr", i), wr_log[0].addr, tbl[i].exp_addr);
                check($sformatf("tbl%0d_data", i), wr_log[0].data, tbl[i].exp_data);
            end
`ifdef PSUM_SATURATE_EN
            check($sformatf("tbl%0d_sat_flag", i), {31'b0, sat_flag}, {31'b0, tbl[i].exp_sat});
`endif
        end

        // Overwrite pass over four consecutive columns; last beat carries gen_done.
        for (int i = 0; i < 4; i++) beats.push_back('{3'd0, 8'h00, 6'd0, 6'(i), 16'(i + 5)});
        run_stream(1'b1, 1000, 0);
        for (int i = 0; i < wr_log.size() && i < 4; i++)
            check("fp_burst_data", wr_log[i].data, 32'(i + 5));

        // Back-to-back same address exercises forwarding from stage C.
        ax = 23'h012345;
        preload(ax, 16'sd100);
        for (int i = 1; i <= 3; i++) beats.push_back('{ax[22:20], ax[19:12], ax[11:6], ax[5:0], 16'(i)});
        run_stream(1'b0, 1000, 0);
        if (wr_log.size() == 3) begin
            check("fwd_c_w0", wr_log[0].data, 32'd101);
            check("fwd_c_w1", wr_log[1].data, 32'd103);
            check("fwd_c_w2", wr_log[2].data, 32'd106);
        end

        // X, Y, X: the second X read races the first X write, so stage D must forward.
        ay = 23'h054321;
        preload(ax, 16'sd50);
        preload(ay, 16'sd0);
        beats.push_back('{ax[22:20], ax[19:12], ax[11:6], ax[5:0], 16'sd1});
        beats.push_back('{ay[22:20], ay[19:12], ay[11:6], ay[5:0], 16'sd10});
        beats.push_back('{ax[22:20], ax[19:12], ax[11:6], ax[5:0], 16'sd2});
        run_stream(1'b0, 1000, 0);
        if (wr_log.size() == 3) begin
            check("fwd_d_w0", wr_log[0].data, 32'd51);
            check("fwd_d_w1", wr_log[1].data, 32'd10);
            check("fwd_d_w2", wr_log[2].data, 32'd53);
        end

        // mem_grant low for three cycles mid-stream.
        for (int i = 0; i < 5; i++) begin
            preload({3'd3, 8'h20, 6'd4, 6'(i)}, 16'(100 * i));
            beats.push_back('{3'd3, 8'h20, 6'd4, 6'(i), 16'(i + 1)});
        end
        run_stream(1'b0, 2, 3);
        for (int i = 0; i < wr_log.size() && i < 5; i++) begin
            check("gate_order", wr_log[i].addr, {3'd3, 8'h20, 6'd4, 6'(i)});
            check("gate_data", wr_log[i].data, 32'(100 * i + i + 1));
        end

        // Reset while stages B and C hold beats: both writes must be dropped.
        wr_log.delete();
        preload(23'h0000A0, 16'sd77);
        preload(23'h0000A1, 16'sd77);
        start = 1'b1; first_pass = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; mem_grant = 1'b1;
        psum_index = 3'd0; channel_index = 8'h00; row_index = 6'd2; col_index = 6'd32; psum_in = 16'sd1;
        tick();
        col_index = 6'd33; psum_in = 16'sd2;
        tick();
        in_valid = 1'b0;
        #1;
        check("rstmid_c_loaded", {31'b0, wr_en}, 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_wr_en", {31'b0, wr_en}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_await", {31'b0, await}, 32'd1);
        tick();
        check("rstmid_wr_en_next", {31'b0, wr_en}, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("rstmid_no_writes", wr_log.size(), 32'd0);
        check("rstmid_mem_a0", sram_rd(23'h0000A0), 32'd77);
        check("rstmid_mem_a1", sram_rd(23'h0000A1), 32'd77);

        // gen_done in IDLE must not start anything.
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("idle_gen_done_busy", {31'b0, busy}, 32'd0);
        check("idle_gen_done_await", {31'b0, await}, 32'd1);
        tick();
        #2;
        check("idle_gen_done_no_done", {31'b0, done}, 32'd0);
        tick();

        // Normal job after the aborted one.
        preload(23'h0000A0, 16'sd77);
        beats.push_back('{3'd0, 8'h00, 6'd2, 6'd32, 16'sd3});
        run_stream(1'b0, 1000, 0);
        if (wr_log.size() > 0) check("recover_data", wr_log[0].data, 32'd80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
